adc_readout_serializer: RTL

Digital-side reader for the SAR ADC slice: captures each 9-bit conversion result from the ADC's parallel `data_out` bus, buffers it, and streams it MSB-first over a 3-wire serial port (sck/sdo/frame_n) on GPIO pads. It lives in `core` next to the ADC instance. It replaces the 8 parallel data pads with 3 pins and keeps all 9 bits.

---
 rtl/adc_readout_pkg.sv | 21 ++
 rtl/adc_sample_fifo.sv | 69 ++++++
 rtl/adc_readout_serializer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/adc_readout_pkg.sv
// adc_readout_pkg
// Shared definitions for the ADC readout serializer slice:
//   DATA_W_DEFAULT - default ADC result width
//   ser_state_t    - serializer FSM state encoding
//   level_width()  - width of a FIFO occupancy count for a given depth
package adc_readout_pkg;

    localparam int DATA_W_DEFAULT = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } ser_state_t;

    // Occupancy must be able to represent DEPTH itself, hence the +1.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo
// Synchronous FIFO with a combinational read head (first-word fall-through).
// Ports:
//   clock, reset     - rising-edge clock, synchronous active-high reset
//   push, wr_data    - write request and data
//   pop              - read request; advances past the head shown on rd_data
//   rd_data          - current head entry
//   full, empty      - occupancy flags
//   level            - current occupancy (0..DEPTH)
// A push while full is accepted only if a pop happens in the same cycle.
module adc_sample_fifo
    import adc_readout_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEFAULT,
    parameter int DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/adc_readout_serializer.sv
// adc_readout_serializer
// Captures each ADC conversion result on the rising edge of adc_done,
// buffers it, and streams it MSB-first on a 3-wire serial port.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   enable        - capture/stream enable
//   adc_data      - ADC result, stable for >=4 clocks after adc_done rises
//   adc_done      - asynchronous conversion-complete strobe
//   sck, sdo      - serial clock (idles low) and data (changes on sck fall)
//   frame_n       - active-low word frame
//   overflow      - sticky flag, set when a sample is dropped on a full FIFO
//   fifo_level    - FIFO occupancy
//
// Serializer states:
//   state    | meaning
//   ST_IDLE  | waiting for a buffered word with enable high
//   ST_SHIFT | frame_n low; each bit CLK_DIV clocks sck low, CLK_DIV high
//   ST_GAP   | frame_n high, sck/sdo low for 2*CLK_DIV clocks
module adc_readout_serializer
    import adc_readout_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [DATA_W-1:0]                  adc_data,
    input  logic                               adc_done,
    output logic                               sck,
    output logic                               sdo,
    output logic                               frame_n,
    output logic                               overflow,
    output logic [level_width(FIFO_DEPTH)-1:0] fifo_level
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LOAD = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DATA_W - 1);

    logic              done_meta;
    logic              done_sync;
    logic              done_prev;
    logic              cap_req;

    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              start_word;

    ser_state_t        state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] rest;

    always_ff @(posedge clock) begin
        if (reset) begin
            done_meta <= 1'b0;
            done_sync <= 1'b0;
            done_prev <= 1'b0;
        end else begin
            done_meta <= adc_done;
            done_sync <= done_meta;
            done_prev <= done_sync;
        end
    end

    assign cap_req = done_sync && !done_prev && enable;

    // Popping straight out of the last gap cycle keeps back-to-back words
    // separated by exactly 2*CLK_DIV clocks instead of paying an IDLE cycle.
    assign start_word = enable && !fifo_empty &&
                        ((state == ST_IDLE) || (state == ST_GAP && div_cnt == '0));

    adc_sample_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (cap_req),
        .wr_data (adc_data),
        .pop     (start_word),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (cap_req && fifo_full && !start_word) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            sck     <= 1'b0;
            sdo     <= 1'b0;
            frame_n <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            rest    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_word) begin
                        state   <= ST_SHIFT;
                        frame_n <= 1'b0;
                        sck     <= 1'b0;
                        sdo     <= fifo_rd_data[DATA_W-1];
                        rest    <= fifo_rd_data[DATA_W-2:0];
                        div_cnt <= DIV_LOAD;
                        bit_cnt <= BIT_LOAD;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end else if (!sck) begin
                        sck     <= 1'b1;
                        div_cnt <= DIV_LOAD;
                    end else if (bit_cnt == '0) begin
                        state   <= ST_GAP;
                        frame_n <= 1'b1;
                        sck     <= 1'b0;
                        sdo     <= 1'b0;
                        div_cnt <= GAP_LOAD;
                    end else begin
                        sck     <= 1'b0;
                        sdo     <= rest[DATA_W-2];
                        rest    <= rest << 1;
                        bit_cnt <= bit_cnt - BIT_W'(1);
                        div_cnt <= DIV_LOAD;
                    end
                end
                ST_GAP: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end else if (start_word) begin
                        state   <= ST_SHIFT;
                        frame_n <= 1'b0;
                        sck     <= 1'b0;
                        sdo     <= fifo_rd_data[DATA_W-1];
                        rest    <= fifo_rd_data[DATA_W-2:0];
                        div_cnt <= DIV_LOAD;
                        bit_cnt <= BIT_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
